uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_rx_oversample.sv | 132 +++++++++++++
 tb/tb_uart_rx_oversample.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1, LSB first) running on a baud_tick enable.
// The start bit is qualified at mid-bit. Data and stop bits are then sampled one bit period apart.
module uart_rx_oversample #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 rxs;

    assign rxs     = sync2_q;
    assign shift_d = {rxs, shift_q[DATA_BITS-1:1]};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // Both synchronizer flops reset to the idle-high level, so a reset cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            prev_q      <= 1'b1;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (baud_tick) begin
                // prev_q holds the line as seen on the previous tick; edge detection depends on it
                prev_q <= rxs;
                case (state_q)
                    IDLE: begin
                        if (!rxs && prev_q) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_q <= '0;
                            if (rxs) begin
                                state_q <= IDLE;
                            end else begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_d;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= IDLE;
                            if (rxs) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample. The stimulus pushes the expected pulses and a negedge monitor pops them.
// The frames cover clean data, a glitch, a framing error, back-to-back frames, a mid-frame reset and a sparse baud_tick.
module tb_uart_rx_oversample;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;
    int         div = 1;
    int         tcnt = 0;
    logic       tick_at_edge = 1'b0;
    logic       prev_pulse = 1'b0;

    uart_rx_oversample #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .serial_in(serial_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Baud generator: when div is 1 the tick is tied high, otherwise it is one pulse every div clocks
    always @(negedge clk) begin
        if (div <= 1) begin
            baud_tick = 1'b1;
        end else begin
            baud_tick = (tcnt == 0);
            tcnt      = (tcnt + 1) % div;
        end
    end

    always @(posedge clk) tick_at_edge <= baud_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse is compared against the oldest entry in the scoreboard
    always @(negedge clk) begin
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
            check("no_dual_pulse", {31'd0, rx_valid & frame_err}, 32'd0);
            check("pulse_after_tick", {31'd0, tick_at_edge}, 32'd1);
            check("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h expected no pulse at %0t",
                         rx_valid, frame_err, rx_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
        prev_pulse = rx_valid | frame_err;
    end

    task automatic hold_bit();
        repeat (16 * div) @(negedge clk);
    endtask

    task automatic idle(input int ticks);
        repeat (ticks * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? d : last_good;
        if (stop) last_good = d;
        exp_q.push_back(e);
        serial_in = 1'b0;
        hold_bit();
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            hold_bit();
        end
        serial_in = stop;
        hold_bit();
    endtask

    initial begin
        logic [7:0] r55;
        r55 = 8'h55;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(20);

        // Clean frame, tick tied high
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);

        // 4-tick low glitch: the receiver must go busy, then fall back to idle silently
        serial_in = 1'b0;
        idle(4);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        serial_in = 1'b1;
        idle(12);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'hA5);

        // Framing error, then the line is held low: there must be no retrigger
        send_frame(8'h3C, 1'b0);
        idle(32);
        check("ferr_no_retrigger", {31'd0, busy}, 32'd0);
        check("ferr_rx_data", {24'd0, rx_data}, 32'hA5);
        serial_in = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1);
        idle(4);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);

        // Reset while bit 4 of 0x55 is on the line
        serial_in = 1'b0;
        hold_bit();
        for (int i = 0; i < 4; i++) begin
            serial_in = r55[i];
            hold_bit();
        end
        serial_in = r55[4];
        idle(8);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        last_good = 8'h00;
        serial_in = 1'b1;
        idle(200);
        check("rst_abandon_busy", {31'd0, busy}, 32'd0);
        check("rst_abandon_data", {24'd0, rx_data}, 32'd0);
        send_frame(8'h12, 1'b1);
        idle(20);

        // Sparse baud_tick: one tick every 5 clocks
        div  = 5;
        tcnt = 0;
        idle(20);
        send_frame(8'hC3, 1'b1);
        idle(20);
        check("c3_rx_data", {24'd0, rx_data}, 32'hC3);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
